// File: rtl/eth_tx_scheduler.sv
// Shares one Ethernet TX byte stream between the ARP reply generator and an application frame generator.
// Optional MIN_PAD_EN: zero-pads short frames up to MIN_LEN bytes through a PAD state.
module eth_tx_scheduler #(
  parameter int MAX_LEN    = 1514,
  parameter int IFG_CYCLES = 12,
  parameter int MIN_LEN    = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arp_req,
  input  logic [47:0] req_mac,
  input  logic [31:0] req_ip,
  output logic [47:0] arp_mac,
  output logic [31:0] arp_ip,
  input  logic [15:0] arp_plen,
  input  logic [7:0]  arp_pbyte,
  input  logic        app_req,
  output logic        app_ack,
  input  logic [15:0] app_plen,
  input  logic [7:0]  app_pbyte,
  output logic [15:0] pidx,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        tx_last,
  input  logic        tx_ready,
  output logic        busy,
  output logic        arp_ovf
);

  localparam logic [15:0] MAX_L    = 16'(MAX_LEN);
  localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);
`ifdef MIN_PAD_EN
  localparam logic [15:0] MIN_L    = 16'(MIN_LEN);
`endif

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_PAD, S_GAP} state_t;

  state_t      state_q, state_d;
  logic [15:0] pidx_q, pidx_d;
  logic [15:0] frame_len_q, frame_len_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic        tx_valid_q, tx_valid_d;
  logic        tx_last_q, tx_last_d;
  logic        app_ack_q, app_ack_d;
  logic        sel_app_q, sel_app_d;
  logic        last_app_q, last_app_d;
  logic        pend_q, pend_d;
  logic        arp_ovf_q, arp_ovf_d;
  logic [47:0] pend_mac_q, pend_mac_d, arp_mac_q, arp_mac_d;
  logic [31:0] pend_ip_q, pend_ip_d, arp_ip_q, arp_ip_d;
`ifdef MIN_PAD_EN
  logic [15:0] data_len_q, data_len_d;
`endif

  logic        app_active, arp_grant, app_grant;
  logic [15:0] gr_len, gr_tot, pidx_inc;

  always_comb begin
    state_d     = state_q;
    pidx_d      = pidx_q;
    frame_len_d = frame_len_q;
    gap_cnt_d   = gap_cnt_q;
    tx_valid_d  = tx_valid_q;
    tx_last_d   = tx_last_q;
    app_ack_d   = 1'b0;
    sel_app_d   = sel_app_q;
    last_app_d  = last_app_q;
    arp_ovf_d   = arp_ovf_q;
    pend_mac_d  = pend_mac_q;
    pend_ip_d   = pend_ip_q;
    arp_mac_d   = arp_mac_q;
    arp_ip_d    = arp_ip_q;
`ifdef MIN_PAD_EN
    data_len_d  = data_len_q;
`endif

    // app_req is still high during the ack cycle; it must not re-grant then
    app_active = app_req && !app_ack_q;
    arp_grant  = (state_q == S_IDLE) && pend_q && (!app_active || last_app_q);
    app_grant  = (state_q == S_IDLE) && app_active && !arp_grant;

    gr_len = arp_grant ? arp_plen : app_plen;
    if (gr_len > MAX_L) gr_len = MAX_L;
    gr_tot = gr_len;
`ifdef MIN_PAD_EN
    if (gr_len != 16'd0 && gr_len < MIN_L) gr_tot = MIN_L;
`endif
    pidx_inc = pidx_q + 16'd1;

    pend_d = pend_q && !arp_grant;
    if (arp_req) begin
      pend_d     = 1'b1;
      pend_mac_d = req_mac;
      pend_ip_d  = req_ip;
      if (pend_q && !arp_grant) arp_ovf_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (arp_grant || app_grant) begin
          sel_app_d  = app_grant;
          last_app_d = app_grant;
          app_ack_d  = app_grant;
          if (arp_grant) begin
            arp_mac_d = pend_mac_q;
            arp_ip_d  = pend_ip_q;
          end
          if (gr_tot != 16'd0) begin
            state_d     = S_SEND;
            tx_valid_d  = 1'b1;
            tx_last_d   = (gr_tot == 16'd1);
            frame_len_d = gr_tot;
            pidx_d      = 16'd0;
`ifdef MIN_PAD_EN
            data_len_d  = gr_len;
`endif
          end
        end
      end
      S_SEND, S_PAD: begin
        if (tx_ready) begin
          if (tx_last_q) begin
            pidx_d     = 16'd0;
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
            gap_cnt_d  = 16'd0;
            state_d    = (IFG_CYCLES > 0) ? S_GAP : S_IDLE;
          end else begin
            pidx_d    = pidx_inc;
            tx_last_d = (pidx_inc == frame_len_q - 16'd1);
`ifdef MIN_PAD_EN
            if (pidx_inc >= data_len_q) state_d = S_PAD;
`endif
          end
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q + 16'd1;
        if (gap_cnt_q == IFG_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pidx_q      <= '0;
      frame_len_q <= '0;
      gap_cnt_q   <= '0;
      tx_valid_q  <= 1'b0;
      tx_last_q   <= 1'b0;
      app_ack_q   <= 1'b0;
      sel_app_q   <= 1'b0;
      last_app_q  <= 1'b0;
      pend_q      <= 1'b0;
      arp_ovf_q   <= 1'b0;
      pend_mac_q  <= '0;
      pend_ip_q   <= '0;
      arp_mac_q   <= '0;
      arp_ip_q    <= '0;
`ifdef MIN_PAD_EN
      data_len_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pidx_q      <= pidx_d;
      frame_len_q <= frame_len_d;
      gap_cnt_q   <= gap_cnt_d;
      tx_valid_q  <= tx_valid_d;
      tx_last_q   <= tx_last_d;
      app_ack_q   <= app_ack_d;
      sel_app_q   <= sel_app_d;
      last_app_q  <= last_app_d;
      pend_q      <= pend_d;
      arp_ovf_q   <= arp_ovf_d;
      pend_mac_q  <= pend_mac_d;
      pend_ip_q   <= pend_ip_d;
      arp_mac_q   <= arp_mac_d;
      arp_ip_q    <= arp_ip_d;
`ifdef MIN_PAD_EN
      data_len_q  <= data_len_d;
`endif
    end
  end

  // Generators answer combinationally from pidx, so a stalled index holds the byte
  assign tx_data  = (state_q == S_PAD) ? 8'h00 : (sel_app_q ? app_pbyte : arp_pbyte);
  assign tx_valid = tx_valid_q;
  assign tx_last  = tx_last_q;
  assign pidx     = pidx_q;
  assign app_ack  = app_ack_q;
  assign arp_mac  = arp_mac_q;
  assign arp_ip   = arp_ip_q;
  assign arp_ovf  = arp_ovf_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Randomized bench for eth_tx_scheduler: byte streams compared against a frame-level expected queue.
module tb_eth_tx_scheduler;
  logic        clk = 1'b0;
  logic        rst, arp_req, app_req, tx_ready;
  logic [47:0] req_mac, arp_mac;
  logic [31:0] req_ip, arp_ip;
  logic [15:0] arp_plen, app_plen, pidx;
  logic [7:0]  arp_pbyte, app_pbyte, tx_data;
  logic        app_ack, tx_valid, tx_last, busy, arp_ovf;

  always #5 clk = ~clk;

`ifdef MIN_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  // Stand-in generators: ARP bytes depend on the latched requester MAC
  assign arp_plen  = 16'd42;
  assign arp_pbyte = arp_mac[7:0] ^ pidx[7:0];
  assign app_pbyte = pidx[7:0] + 8'h30;

  eth_tx_scheduler dut (
    .clk(clk), .rst(rst), .arp_req(arp_req), .req_mac(req_mac), .req_ip(req_ip),
    .arp_mac(arp_mac), .arp_ip(arp_ip), .arp_plen(arp_plen), .arp_pbyte(arp_pbyte),
    .app_req(app_req), .app_ack(app_ack), .app_plen(app_plen), .app_pbyte(app_pbyte),
    .pidx(pidx), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .busy(busy), .arp_ovf(arp_ovf)
  );

  int vectors = 0, errors = 0;

  logic [7:0]  got_d[$], exp_d[$];
  bit          got_l[$], exp_l[$], exp_arp[$];
  logic [47:0] got_m[$], exp_m[$];
  int          ack_cnt = 0, stall_viol = 0;
  bit          prev_stall = 1'b0, prev_l = 1'b0;
  logic [7:0]  prev_d = 8'h00;

  always @(negedge clk) begin
    if (rst) prev_stall <= 1'b0;
    else begin
      if (app_ack) ack_cnt <= ack_cnt + 1;
      if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_d || tx_last !== prev_l))
        stall_viol <= stall_viol + 1;
      if (tx_valid && tx_ready) begin
        got_d.push_back(tx_data);
        got_l.push_back(tx_last);
        got_m.push_back(arp_mac);
      end
      prev_stall <= tx_valid && !tx_ready;
      prev_d     <= tx_data;
      prev_l     <= tx_last;
    end
  end

  function automatic void add_arp(input logic [47:0] m);
    int tot = PAD ? 60 : 42;
    for (int i = 0; i < tot; i++) begin
      exp_d.push_back(i < 42 ? (m[7:0] ^ 8'(i)) : 8'h00);
      exp_l.push_back(i == tot - 1);
      exp_arp.push_back(1'b1);
      exp_m.push_back(m);
    end
  endfunction

  function automatic void add_app(input int len);
    int eff = (len > 1514) ? 1514 : len;
    int tot = (PAD && eff > 0 && eff < 60) ? 60 : eff;
    for (int i = 0; i < tot; i++) begin
      exp_d.push_back(i < eff ? 8'(i) + 8'h30 : 8'h00);
      exp_l.push_back(i == tot - 1);
      exp_arp.push_back(1'b0);
      exp_m.push_back(48'h0);
    end
  endfunction

  // Number of positions where the observed stream departs from the expected one
  function automatic int stream_diff(output int first);
    int n = 0;
    int m = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
    first = -1;
    for (int i = 0; i < m; i++)
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i] || (exp_arp[i] && got_m[i] !== exp_m[i])) begin
        if (first < 0) first = i;
        n++;
      end
    if (got_d.size() != exp_d.size()) n++;
    return n;
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; arp_req = 1'b0; app_req = 1'b0; tx_ready = 1'b1;
    app_plen = 16'd0; req_mac = 48'h0; req_ip = 32'h0;
    repeat (2) tick;
    rst = 1'b0;
    got_d.delete(); got_l.delete(); got_m.delete();
    exp_d.delete(); exp_l.delete(); exp_arp.delete(); exp_m.delete();
  endtask

  task automatic pulse_arp(input logic [47:0] m, input logic [31:0] ip);
    arp_req = 1'b1; req_mac = m; req_ip = ip;
    tick;
    arp_req = 1'b0;
  endtask

  task automatic run_until(input int n, input int budget, input bit rnd, input int ack_base,
                           input int acks_want, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick;
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ack_cnt - ack_base >= acks_want) app_req = 1'b0;
      if (got_d.size() >= n) begin ok = 1'b1; break; end
    end
    tx_ready = 1'b1;
    repeat (30) tick;
  endtask

  task automatic test_reset;
    do_reset;
    @(negedge clk);
    vectors++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
    vectors++; if (tx_last !== 1'b0) begin errors++; $display("FAIL rst_tx_last: got %b want 0", tx_last); end
    vectors++; if (pidx !== 16'd0) begin errors++; $display("FAIL rst_pidx: got %0d want 0", pidx); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    vectors++; if (app_ack !== 1'b0) begin errors++; $display("FAIL rst_app_ack: got %b want 0", app_ack); end
    vectors++; if (arp_ovf !== 1'b0) begin errors++; $display("FAIL rst_arp_ovf: got %b want 0", arp_ovf); end
    vectors++; if (arp_mac !== 48'h0 || arp_ip !== 32'h0) begin
      errors++; $display("FAIL rst_arp_addr: got %h/%h want 0/0", arp_mac, arp_ip); end
  endtask

  task automatic test_arp_basic;
    logic [47:0] m = 48'h02AABBCCDDEE;
    logic [31:0] ip = 32'h0A0A0A01;
    int idle_bad = 0, first;
    bit seen_last = 1'b0;
    do_reset;
    add_arp(m);
    pulse_arp(m, ip);
    @(negedge clk);
    vectors++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL arp_lat_n1: tx_valid %b want 0", tx_valid); end
    @(negedge clk);
    vectors++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL arp_lat_n2: tx_valid %b want 1", tx_valid); end
    vectors++; if (pidx !== 16'd0 || tx_data !== m[7:0]) begin
      errors++; $display("FAIL arp_first: pidx %0d data %h want 0 %h", pidx, tx_data, m[7:0]); end
    vectors++; if (arp_ip !== ip) begin errors++; $display("FAIL arp_ip: got %h want %h", arp_ip, ip); end
    for (int c = 0; c < 200 && !seen_last; c++) begin
      if (tx_valid && tx_last && tx_ready) seen_last = 1'b1;
      else @(negedge clk);
    end
    vectors++; if (!seen_last) begin errors++; $display("FAIL arp_last_timeout: no tx_last within 200 cycles"); end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (tx_valid) idle_bad++;
    end
    vectors++; if (idle_bad !== 0) begin errors++; $display("FAIL arp_ifg: %0d valid cycles in gap, want 0", idle_bad); end
    repeat (3) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL arp_idle_busy: got %b want 0", busy); end
    vectors++; if (stream_diff(first) !== 0) begin
      errors++; $display("FAIL arp_stream: first bad %0d, got %0d bytes want %0d", first, got_d.size(), exp_d.size()); end
  endtask

  task automatic test_round_robin;
    logic [47:0] ma = 48'h0211223344A1, mb = 48'h0255667788B2;
    int ack0, first;
    bit sent_b = 1'b0, ok = 1'b0;
    do_reset;
    ack0 = ack_cnt;
    add_app(10); add_arp(ma); add_app(10); add_arp(mb);
    app_plen = 16'd10; app_req = 1'b1;
    pulse_arp(ma, 32'hC0A80001);
    for (int c = 0; c < 3000; c++) begin
      tick;
      if (ack_cnt - ack0 >= 2) app_req = 1'b0;
      if (!sent_b && arp_mac == ma) begin sent_b = 1'b1; pulse_arp(mb, 32'hC0A80002); end
      if (got_d.size() >= exp_d.size() && !app_req) begin ok = 1'b1; break; end
    end
    repeat (30) tick;
    vectors++; if (!ok) begin errors++; $display("FAIL rr_timeout: %0d bytes of %0d", got_d.size(), exp_d.size()); end
    vectors++; if (ack_cnt - ack0 !== 2) begin errors++; $display("FAIL rr_acks: got %0d want 2", ack_cnt - ack0); end
    vectors++; if (arp_ovf !== 1'b0) begin errors++; $display("FAIL rr_ovf: got %b want 0", arp_ovf); end
    vectors++; if (stream_diff(first) !== 0) begin
      errors++; $display("FAIL rr_stream: first bad %0d, got %0d bytes want %0d", first, got_d.size(), exp_d.size()); end
  endtask

  task automatic test_stall;
    for (int r = 0; r < 3; r++) begin
      int len = $urandom_range(1, 80);
      logic [47:0] m = {16'h0200, 32'($urandom)};
      int ack0, sv0, first;
      bit ok;
      do_reset;
      ack0 = ack_cnt; sv0 = stall_viol;
      add_app(len); add_arp(m);
      app_plen = 16'(len); app_req = 1'b1;
      pulse_arp(m, 32'($urandom));
      run_until(exp_d.size(), 2000, 1'b1, ack0, 1, ok);
      vectors++; if (!ok) begin errors++; $display("FAIL stall_timeout: round %0d, %0d bytes", r, got_d.size()); end
      vectors++; if (stall_viol - sv0 !== 0) begin
        errors++; $display("FAIL stall_hold: %0d changes while stalled, want 0", stall_viol - sv0); end
      vectors++; if (ack_cnt - ack0 !== 1) begin errors++; $display("FAIL stall_acks: got %0d want 1", ack_cnt - ack0); end
      vectors++; if (stream_diff(first) !== 0) begin
        errors++; $display("FAIL stall_stream: len %0d first bad %0d, got %0d want %0d", len, first, got_d.size(), exp_d.size()); end
    end
  endtask

  task automatic test_ovf;
    logic [47:0] md = 48'h02000000D001, me = 48'h02000000E002;
    int ack0, first;
    bit ok = 1'b0;
    do_reset;
    ack0 = ack_cnt;
    add_app(30); add_arp(me);
    app_plen = 16'd30; app_req = 1'b1;
    for (int c = 0; c < 20 && !ok; c++) begin tick; if (ack_cnt != ack0) ok = 1'b1; end
    vectors++; if (!ok) begin errors++; $display("FAIL ovf_ack_timeout: no app_ack within 20 cycles"); end
    app_req = 1'b0;
    pulse_arp(md, 32'h0A000001);
    tick; tick;
    pulse_arp(me, 32'h0A000002);
    tick;
    vectors++; if (arp_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", arp_ovf); end
    run_until(exp_d.size(), 500, 1'b0, ack0, 1, ok);
    vectors++; if (!ok) begin errors++; $display("FAIL ovf_timeout: %0d bytes", got_d.size()); end
    vectors++; if (arp_ip !== 32'h0A000002) begin errors++; $display("FAIL ovf_ip: got %h want 0a000002", arp_ip); end
    vectors++; if (stream_diff(first) !== 0) begin
      errors++; $display("FAIL ovf_stream: first bad %0d, got %0d bytes want %0d", first, got_d.size(), exp_d.size()); end
  endtask

  task automatic test_len_edges;
    int ack0, first;
    bit ok = 1'b0;
    do_reset;
    ack0 = ack_cnt;
    app_plen = 16'd0; app_req = 1'b1;
    for (int c = 0; c < 20 && !ok; c++) begin @(negedge clk); if (app_ack) ok = 1'b1; end
    vectors++; if (!ok) begin errors++; $display("FAIL len0_ack: no app_ack within 20 cycles"); end
    vectors++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL len0_idle: busy %b tx_valid %b want 0 0", busy, tx_valid); end
    tick; app_req = 1'b0;
    repeat (10) tick;
    vectors++; if (got_d.size() !== 0 || ack_cnt - ack0 !== 1) begin
      errors++; $display("FAIL len0_quiet: %0d bytes %0d acks want 0 1", got_d.size(), ack_cnt - ack0); end
    ack0 = ack_cnt;
    add_app(2000);
    app_plen = 16'd2000; app_req = 1'b1;
    run_until(exp_d.size(), 2500, 1'b0, ack0, 1, ok);
    vectors++; if (!ok) begin errors++; $display("FAIL len_max_timeout: %0d bytes", got_d.size()); end
    vectors++; if (got_d.size() !== 1514) begin errors++; $display("FAIL len_max_count: got %0d want 1514", got_d.size()); end
    vectors++; if (stream_diff(first) !== 0) begin
      errors++; $display("FAIL len_max_stream: first bad %0d, got %0d want %0d", first, got_d.size(), exp_d.size()); end
  endtask

  task automatic test_reset_mid;
    bit ok = 1'b0, reload = 1'b0;
    do_reset;
    pulse_arp(48'h020000000F01, 32'h0A0A0A09);
    for (int c = 0; c < 100 && !ok; c++) begin
      tick;
      if (!reload && got_d.size() == 10) begin reload = 1'b1; pulse_arp(48'h020000000F02, 32'h0A0A0A0A); end
      if (got_d.size() == 20) ok = 1'b1;
    end
    vectors++; if (!ok) begin errors++; $display("FAIL rmid_timeout: %0d bytes", got_d.size()); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    vectors++; if (tx_valid !== 1'b0 || tx_last !== 1'b0 || pidx !== 16'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL rmid_outputs: valid %b last %b pidx %0d busy %b want 0", tx_valid, tx_last, pidx, busy); end
    vectors++; if (arp_mac !== 48'h0 || arp_ip !== 32'h0 || arp_ovf !== 1'b0 || app_ack !== 1'b0) begin
      errors++; $display("FAIL rmid_regs: mac %h ip %h ovf %b ack %b want 0", arp_mac, arp_ip, arp_ovf, app_ack); end
    tick; rst = 1'b0;
    got_d.delete(); got_l.delete(); got_m.delete();
    repeat (15) tick;
    vectors++; if (got_d.size() !== 0) begin errors++; $display("FAIL rmid_pend: %0d bytes after reset want 0", got_d.size()); end
  endtask

  initial begin
    test_reset;
    test_arp_basic;
    test_round_robin;
    test_stall;
    test_ovf;
    test_len_edges;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
